ysyx_22040125_mem_arb: RTL

- Arbitrates a single shared memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU) of the RV64 core.
- The LSU drives its port from decoder outputs (data_ren/data_wen, byte-enable derived from s_bhwd/l_bhw).
- Exactly one transaction is outstanding at a time.
- Fixed LSU priority, with a streak counter that prevents IFU starvation.

---
 rtl/ysyx_22040125_mem_arb_pkg.sv | 29 ++
 rtl/ysyx_22040125_mem_arb_if.sv | 48 ++++
 rtl/ysyx_22040125_arb_pick.sv | 33 +++
 rtl/ysyx_22040125_mem_arb.sv | 110 +++++++++++
 4 files changed

// File: rtl/ysyx_22040125_mem_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: widths, FSM/owner encodings
// and the request payload held while a transaction is in flight.
package ysyx_22040125_mem_arb_pkg;

  localparam int unsigned ADDR_W             = 64;
  localparam int unsigned DATA_W             = 64;
  localparam int unsigned STRB_W             = DATA_W / 8;
  localparam int unsigned DEF_MAX_LSU_STREAK = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2
  } owner_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } mem_req_t;

endpackage

// File: rtl/ysyx_22040125_mem_arb_if.sv
// Bundle of the IFU, LSU and downstream memory handshakes around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/memory.
interface ysyx_22040125_mem_arb_if;
  import ysyx_22040125_mem_arb_pkg::*;

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [STRB_W-1:0] lsu_wstrb;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wstrb,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wstrb,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );

endinterface

// File: rtl/ysyx_22040125_arb_pick.sv
// Combinational grant decision: LSU wins unless IFU has waited through a full
// LSU streak; also produces the streak value to load on this cycle.
module ysyx_22040125_arb_pick #(
  parameter int unsigned MAX_LSU_STREAK = 4,
  parameter int unsigned STREAK_W       = 3
) (
  input  logic                ifu_valid,
  input  logic                lsu_valid,
  input  logic [STREAK_W-1:0] streak,
  input  logic                in_idle,
  output logic                grant_ifu,
  output logic                grant_lsu,
  output logic [STREAK_W-1:0] streak_nxt
);

  logic streak_full;

  assign streak_full = (streak == STREAK_W'(MAX_LSU_STREAK));

  always_comb begin
    grant_lsu  = in_idle && lsu_valid && !(ifu_valid && streak_full);
    grant_ifu  = in_idle && ifu_valid && !grant_lsu;
    streak_nxt = streak;
    if (grant_ifu) begin
      streak_nxt = '0;
    end else if (grant_lsu) begin
      // Only count LSU wins that actually made the IFU wait.
      if (!ifu_valid)       streak_nxt = '0;
      else if (!streak_full) streak_nxt = streak + STREAK_W'(1);
    end
  end

endmodule

// File: rtl/ysyx_22040125_mem_arb.sv
// Single-outstanding memory arbiter between IFU fetches and LSU loads/stores.
// Grants in IDLE, presents the held request in REQ, routes the reply in WAIT.
module ysyx_22040125_mem_arb
  import ysyx_22040125_mem_arb_pkg::*;
#(
  parameter int unsigned MAX_LSU_STREAK = DEF_MAX_LSU_STREAK
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ysyx_22040125_mem_arb_if.slave        bus
);

  localparam int unsigned STREAK_W = $clog2(MAX_LSU_STREAK + 1);

  arb_state_e          state_q,  state_d;
  owner_e              owner_q,  owner_d;
  mem_req_t            hold_q,   hold_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  logic                in_idle;
  logic                grant_ifu;
  logic                grant_lsu;
  logic [STREAK_W-1:0] streak_nxt;
  logic                ifu_resp_valid;
  logic                lsu_resp_valid;

  // Gating with rst_n keeps the combinational readies low throughout reset.
  assign in_idle = rst_n && (state_q == ARB_IDLE);

  ysyx_22040125_arb_pick #(
    .MAX_LSU_STREAK (MAX_LSU_STREAK),
    .STREAK_W       (STREAK_W)
  ) u_pick (
    .ifu_valid  (bus.ifu_req_valid),
    .lsu_valid  (bus.lsu_req_valid),
    .streak     (streak_q),
    .in_idle    (in_idle),
    .grant_ifu  (grant_ifu),
    .grant_lsu  (grant_lsu),
    .streak_nxt (streak_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_NONE;
      hold_q   <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      hold_q   <= hold_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    hold_d         = hold_q;
    streak_d       = streak_nxt;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (grant_lsu) begin
          hold_d.addr  = bus.lsu_addr;
          hold_d.wen   = bus.lsu_wen;
          hold_d.wdata = bus.lsu_wdata;
          hold_d.wstrb = bus.lsu_wen ? bus.lsu_wstrb : STRB_W'(0);
          owner_d      = OWN_LSU;
          state_d      = ARB_REQ;
        end else if (grant_ifu) begin
          hold_d       = '0;
          hold_d.addr  = bus.ifu_addr;
          owner_d      = OWN_IFU;
          state_d      = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (bus.mem_req_ready) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (bus.mem_resp_valid) begin
          ifu_resp_valid = (owner_q == OWN_IFU);
          lsu_resp_valid = (owner_q == OWN_LSU);
          owner_d        = OWN_NONE;
          state_d        = ARB_IDLE;
        end
      end
      default: begin
        owner_d = OWN_NONE;
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign bus.ifu_req_ready  = grant_ifu;
  assign bus.lsu_req_ready  = grant_lsu;
  assign bus.ifu_resp_valid = ifu_resp_valid;
  assign bus.lsu_resp_valid = lsu_resp_valid;
  assign bus.ifu_rdata      = bus.mem_rdata;
  assign bus.lsu_rdata      = bus.mem_rdata;
  assign bus.mem_req_valid  = (state_q == ARB_REQ);
  assign bus.mem_addr       = hold_q.addr;
  assign bus.mem_wen        = hold_q.wen;
  assign bus.mem_wdata      = hold_q.wdata;
  assign bus.mem_wstrb      = hold_q.wstrb;

endmodule
